traffic_controller_param: RTL and testbench
===========================================

Name: traffic_controller_param

Overview:
- Parametrised, next-generation highway/country-road intersection controller.
- Delay lengths are configurable, and every red-to-green handover in both directions passes through an all-red interval.
- Adds minimum highway green, maximum country green, a latched pedestrian request with walk indication, and a night flashing mode.
- Sits directly behind the sensor inputs and drives the lamp drivers through the 2-bit lamp code: RED=0, YELLOW=1, GREEN=2, OFF=3.

Parameters:
CNT_W, 8, dwell-counter width; every delay parameter is in 1..2^CNT_W-1
Y2R_DELAY, 3, cycles of yellow before red, used in both directions
R2G_DELAY, 2, cycles of all-red before any green
MIN_HWY_GREEN, 4, minimum highway-green residency in cycles
MIN_CNTRY_GREEN, 2, minimum country-green residency in cycles
MAX_CNTRY_GREEN, 8, maximum country-green residency in cycles; must be >= MIN_CNTRY_GREEN
FLASH_HALF, 4, cycles per half-period of night flashing

Ports:
clock  input  1  system clock; all state changes on rising edge
clear_n  input  1  asynchronous active-low reset
X  input  1  country-road car sensor, level
ped_req  input  1  pedestrian push-button, may be a single-cycle pulse
night_mode  input  1  night flashing request, level
hwy  output  2  highway lamp code
cntry  output  2  country lamp code
walk  output  1  pedestrian walk lamp
ped_pending  output  1  latched pedestrian request not yet served
state_o  output  3  current state encoding, for debug

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: clear_n low forces reset immediately, including mid-sequence.
- Reset values:
  - state = HWY_GREEN, counter = 0, flash phase = 1, ped_pending = 0.
  - Outputs: hwy = GREEN, cntry = RED, walk = 0, state_o = 0.
- All outputs decode only from registers (state, flash phase, ped_pending). There is no combinational path from any input to any output.
- State encodings for state_o: HWY_GREEN=0, HWY_YELLOW=1, ALL_RED_A=2, CNTRY_GREEN=3, CNTRY_YELLOW=4, ALL_RED_B=5, FLASH=6.
- Unused encoding 7: outputs RED/RED, walk=0, next state ALL_RED_B.
- Counter:
  - Clears to 0 on every state change.
  - Otherwise increments by 1 per cycle, saturating at 2^CNT_W-1.
  - "N cycles" means the transition fires when counter == N-1, so the state is held exactly N cycles.
- Lamp outputs and transitions per state:
  - HWY_GREEN: hwy GREEN, cntry RED.
    - If night_mode=1, go to FLASH next cycle. This has priority and ignores the minimum green.
    - Else if (X or ped_pending) and counter >= MIN_HWY_GREEN-1, go to HWY_YELLOW.
  - HWY_YELLOW: hwy YELLOW, cntry RED; go to ALL_RED_A after Y2R_DELAY cycles.
  - ALL_RED_A: RED/RED; go to CNTRY_GREEN after R2G_DELAY cycles.
  - CNTRY_GREEN: hwy RED, cntry GREEN, walk=1.
    - Go to CNTRY_YELLOW when counter >= MIN_CNTRY_GREEN-1 and (X=0 or counter >= MAX_CNTRY_GREEN-1).
  - CNTRY_YELLOW: hwy RED, cntry YELLOW; go to ALL_RED_B after Y2R_DELAY cycles.
  - ALL_RED_B: RED/RED; go to HWY_GREEN after R2G_DELAY cycles.
  - FLASH:
    - Phase is set to 1 on entry and toggles each time counter reaches FLASH_HALF-1; the counter restarts at 0 on each toggle.
    - phase=1: hwy YELLOW, cntry RED. phase=0: hwy OFF, cntry OFF.
    - When night_mode=0, go to ALL_RED_B.
- night_mode is ignored in every state except HWY_GREEN and FLASH.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the cycle the controller enters CNTRY_GREEN. A request arriving on that same cycle is discarded; clear wins.
  - While in CNTRY_GREEN or FLASH, ped_req is not latched and ped_pending stays 0.
- X and ped_pending have no effect outside HWY_GREEN / CNTRY_GREEN beyond what is stated above.
- Highway and country lamps are never GREEN or YELLOW simultaneously, in any state.

Test Plan (default parameters):
- Reset/idle: clear_n low 3 cycles, then high with X=0 for 20 cycles -> hwy=2, cntry=0, walk=0, state_o=0 throughout.
- Country cycle: X=1 at cycle 10 after reset, dropped after 5 cycles of CNTRY_GREEN -> 3 cycles hwy=1; 2 cycles 0/0; 5 cycles cntry=2 with walk=1; 3 cycles cntry=1; 2 cycles 0/0; then hwy=2.
- Max green: X held 1 indefinitely -> CNTRY_GREEN lasts exactly 8 cycles; HWY_GREEN then lasts exactly 4 cycles before the next HWY_YELLOW; the period repeats at 22 cycles.
- Pedestrian: single-cycle ped_req with X=0 at least 4 cycles after reset -> ped_pending=1 next cycle; HWY_YELLOW follows; ped_pending=0 from CNTRY_GREEN entry; walk=1 for exactly 2 cycles.
- Night:
  - night_mode=1 raised during CNTRY_GREEN -> no change until HWY_GREEN is reached.
  - Then FLASH: hwy sequence 1,1,1,1,3,3,3,3 repeating, cntry 0,0,0,0,3,3,3,3.
  - night_mode=0 -> 2 cycles 0/0, then hwy=2.
- Async reset: clear_n pulled low mid CNTRY_YELLOW, between clock edges -> hwy=2, cntry=0, walk=0, ped_pending=0 immediately; normal operation resumes from HWY_GREEN after release.

Source files
------------

// File: rtl/traffic_controller_param.sv
// Highway/country-road intersection controller with configurable dwell times,
// all-red handovers, pedestrian request latching and a night flashing mode.
module traffic_controller_param #(
  parameter int CNT_W           = 8,
  parameter int Y2R_DELAY       = 3,
  parameter int R2G_DELAY       = 2,
  parameter int MIN_HWY_GREEN   = 4,
  parameter int MIN_CNTRY_GREEN = 2,
  parameter int MAX_CNTRY_GREEN = 8,
  parameter int FLASH_HALF      = 4
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       X,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_HWY_GREEN    = 3'd0,
    S_HWY_YELLOW   = 3'd1,
    S_ALL_RED_A    = 3'd2,
    S_CNTRY_GREEN  = 3'd3,
    S_CNTRY_YELLOW = 3'd4,
    S_ALL_RED_B    = 3'd5,
    S_FLASH        = 3'd6,
    S_ILLEGAL      = 3'd7
  } state_t;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;
  localparam logic [1:0] LAMP_OFF    = 2'd3;

  // Last counter value of each dwell; a state is held for exactly N cycles.
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam logic [CNT_W-1:0] Y2R_LAST      = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] R2G_LAST      = CNT_W'(R2G_DELAY - 1);
  localparam logic [CNT_W-1:0] HWY_MIN_LAST  = CNT_W'(MIN_HWY_GREEN - 1);
  localparam logic [CNT_W-1:0] CNTRY_MIN_LAST = CNT_W'(MIN_CNTRY_GREEN - 1);
  localparam logic [CNT_W-1:0] CNTRY_MAX_LAST = CNT_W'(MAX_CNTRY_GREEN - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST    = CNT_W'(FLASH_HALF - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             phase;
  logic             phase_nxt;
  logic             pend_nxt;
  logic             flash_wrap;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state       <= S_HWY_GREEN;
      cnt         <= '0;
      phase       <= 1'b1;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      phase       <= phase_nxt;
      ped_pending <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    flash_wrap = 1'b0;
    case (state)
      S_HWY_GREEN: begin
        // Night request wins over the minimum-green hold.
        if (night_mode) begin
          state_nxt = S_FLASH;
        end else if ((X || ped_pending) && (cnt >= HWY_MIN_LAST)) begin
          state_nxt = S_HWY_YELLOW;
        end
      end
      S_HWY_YELLOW: begin
        if (cnt >= Y2R_LAST) state_nxt = S_ALL_RED_A;
      end
      S_ALL_RED_A: begin
        if (cnt >= R2G_LAST) state_nxt = S_CNTRY_GREEN;
      end
      S_CNTRY_GREEN: begin
        if ((cnt >= CNTRY_MIN_LAST) && (!X || (cnt >= CNTRY_MAX_LAST))) begin
          state_nxt = S_CNTRY_YELLOW;
        end
      end
      S_CNTRY_YELLOW: begin
        if (cnt >= Y2R_LAST) state_nxt = S_ALL_RED_B;
      end
      S_ALL_RED_B: begin
        if (cnt >= R2G_LAST) state_nxt = S_HWY_GREEN;
      end
      S_FLASH: begin
        if (!night_mode) begin
          state_nxt = S_ALL_RED_B;
        end else if (cnt >= FLASH_LAST) begin
          flash_wrap = 1'b1;
        end
      end
      S_ILLEGAL: state_nxt = S_ALL_RED_B;
      default:   state_nxt = S_ALL_RED_B;
    endcase
  end

  always_comb begin
    cnt_nxt = sat_inc(cnt);
    if ((state_nxt != state) || flash_wrap) begin
      cnt_nxt = '0;
    end
  end

  always_comb begin
    phase_nxt = phase;
    if ((state_nxt == S_FLASH) && (state != S_FLASH)) begin
      phase_nxt = 1'b1;
    end else if (flash_wrap) begin
      phase_nxt = ~phase;
    end
  end

  // Entering country green serves the request; a same-cycle press is dropped.
  always_comb begin
    pend_nxt = ped_pending;
    if (((state_nxt == S_CNTRY_GREEN) && (state != S_CNTRY_GREEN)) ||
        (state == S_CNTRY_GREEN) || (state == S_FLASH)) begin
      pend_nxt = 1'b0;
    end else if (ped_req) begin
      pend_nxt = 1'b1;
    end
  end

  always_comb begin
    hwy   = LAMP_RED;
    cntry = LAMP_RED;
    walk  = 1'b0;
    case (state)
      S_HWY_GREEN:    hwy   = LAMP_GREEN;
      S_HWY_YELLOW:   hwy   = LAMP_YELLOW;
      S_CNTRY_GREEN: begin
        cntry = LAMP_GREEN;
        walk  = 1'b1;
      end
      S_CNTRY_YELLOW: cntry = LAMP_YELLOW;
      S_FLASH: begin
        if (phase) begin
          hwy = LAMP_YELLOW;
        end else begin
          hwy   = LAMP_OFF;
          cntry = LAMP_OFF;
        end
      end
      default: begin
        hwy   = LAMP_RED;
        cntry = LAMP_RED;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_controller_param.sv
// Directed bench for traffic_controller_param with default parameters.
module tb_traffic_controller_param;

  localparam logic [2:0] HG  = 3'd0;
  localparam logic [2:0] HY  = 3'd1;
  localparam logic [2:0] ARA = 3'd2;
  localparam logic [2:0] CG  = 3'd3;
  localparam logic [2:0] CY  = 3'd4;
  localparam logic [2:0] ARB = 3'd5;
  localparam logic [2:0] FL  = 3'd6;

  logic       clock;
  logic       clear_n;
  logic       X;
  logic       ped_req;
  logic       night_mode;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state_o;

  int n_checks;
  int n_errors;

  traffic_controller_param dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .X           (X),
    .ped_req     (ped_req),
    .night_mode  (night_mode),
    .hwy         (hwy),
    .cntry       (cntry),
    .walk        (walk),
    .ped_pending (ped_pending),
    .state_o     (state_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lamp expectations for the non-flashing states, straight from the lamp table.
  function automatic logic [1:0] exp_hwy(input logic [2:0] s);
    case (s)
      HG:      return 2'd2;
      HY:      return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_cntry(input logic [2:0] s);
    case (s)
      CG:      return 2'd2;
      CY:      return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n, input logic [2:0] es, input logic ep, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".state"}, 8'(state_o), 8'(es));
      chk({tag, ".hwy"}, 8'(hwy), 8'(exp_hwy(es)));
      chk({tag, ".cntry"}, 8'(cntry), 8'(exp_cntry(es)));
      chk({tag, ".walk"}, 8'(walk), 8'(es == CG));
      chk({tag, ".ped"}, 8'(ped_pending), 8'(ep));
    end
  endtask

  task automatic run_flash(input int n, input logic [1:0] eh, input logic [1:0] ec, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".state"}, 8'(state_o), 8'(FL));
      chk({tag, ".hwy"}, 8'(hwy), 8'(eh));
      chk({tag, ".cntry"}, 8'(cntry), 8'(ec));
      chk({tag, ".walk"}, 8'(walk), 8'd0);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    clear_n    = 1'b0;
    X          = 1'b0;
    ped_req    = 1'b0;
    night_mode = 1'b0;

    // Reset and idle highway green
    run(3, HG, 1'b0, "reset");
    clear_n = 1'b1;
    run(20, HG, 1'b0, "idle");

    // Country cycle, X dropped after 5 cycles of country green
    X = 1'b1;
    run(3, HY, 1'b0, "cc_hy");
    run(2, ARA, 1'b0, "cc_ara");
    run(5, CG, 1'b0, "cc_cg");
    X = 1'b0;
    run(3, CY, 1'b0, "cc_cy");
    run(2, ARB, 1'b0, "cc_arb");
    run(1, HG, 1'b0, "cc_hg");

    // Max country green with X held, 22-cycle period
    X = 1'b1;
    run(3, HG, 1'b0, "mx_hg0");
    run(3, HY, 1'b0, "mx_hy");
    run(2, ARA, 1'b0, "mx_ara");
    run(8, CG, 1'b0, "mx_cg");
    run(3, CY, 1'b0, "mx_cy");
    run(2, ARB, 1'b0, "mx_arb");
    run(4, HG, 1'b0, "mx_hg");
    run(1, HY, 1'b0, "mx_hy2");
    X = 1'b0;
    run(2, HY, 1'b0, "mn_hy");
    run(2, ARA, 1'b0, "mn_ara");
    run(2, CG, 1'b0, "mn_cg");
    run(3, CY, 1'b0, "mn_cy");
    run(2, ARB, 1'b0, "mn_arb");
    run(1, HG, 1'b0, "mn_hg");

    // Pedestrian request, including a press on the country-green entry edge
    run(4, HG, 1'b0, "pd_wait");
    ped_req = 1'b1;
    run(1, HG, 1'b1, "pd_latch");
    ped_req = 1'b0;
    run(3, HY, 1'b1, "pd_hy");
    run(1, ARA, 1'b1, "pd_ara");
    ped_req = 1'b1;
    run(1, ARA, 1'b1, "pd_ara2");
    run(1, CG, 1'b0, "pd_cg_entry");
    run(1, CG, 1'b0, "pd_cg_hold");
    ped_req = 1'b0;
    run(3, CY, 1'b0, "pd_cy");
    run(2, ARB, 1'b0, "pd_arb");
    run(1, HG, 1'b0, "pd_hg");

    // Night mode raised during country green, flashing, then exit
    X = 1'b1;
    run(3, HG, 1'b0, "nt_hg");
    run(3, HY, 1'b0, "nt_hy");
    run(2, ARA, 1'b0, "nt_ara");
    run(1, CG, 1'b0, "nt_cg0");
    night_mode = 1'b1;
    run(7, CG, 1'b0, "nt_cg");
    run(3, CY, 1'b0, "nt_cy");
    run(2, ARB, 1'b0, "nt_arb");
    run(1, HG, 1'b0, "nt_hg1");
    X = 1'b0;
    run_flash(4, 2'd1, 2'd0, "fl_on0");
    run_flash(4, 2'd3, 2'd3, "fl_off0");
    run_flash(4, 2'd1, 2'd0, "fl_on1");
    run_flash(4, 2'd3, 2'd3, "fl_off1");
    night_mode = 1'b0;
    run(2, ARB, 1'b0, "nx_arb");
    run(1, HG, 1'b0, "nx_hg");

    // Asynchronous reset in the middle of country yellow
    X = 1'b1;
    run(3, HG, 1'b0, "ar_hg");
    run(3, HY, 1'b0, "ar_hy");
    run(2, ARA, 1'b0, "ar_ara");
    run(1, CG, 1'b0, "ar_cg0");
    X = 1'b0;
    run(1, CG, 1'b0, "ar_cg1");
    run(1, CY, 1'b0, "ar_cy0");
    ped_req = 1'b1;
    run(1, CY, 1'b1, "ar_cy1");
    ped_req = 1'b0;
    #3;
    clear_n = 1'b0;
    #1;
    chk("async.state", 8'(state_o), 8'(HG));
    chk("async.hwy", 8'(hwy), 8'd2);
    chk("async.cntry", 8'(cntry), 8'd0);
    chk("async.walk", 8'(walk), 8'd0);
    chk("async.ped", 8'(ped_pending), 8'd0);
    @(posedge clock);
    @(posedge clock);
    #2;
    clear_n = 1'b1;
    run(3, HG, 1'b0, "post_hg");
    X = 1'b1;
    run(1, HY, 1'b0, "post_hy");
    X = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
